// File: rtl/frame_serializer.sv
// frame_serializer: sends {HEADER, payload, optional parity} on one line, BIT_TICKS clocks per bit,
// with ready/busy/done handshaking.
module frame_serializer #(
  parameter int              DATA_W    = 5,
  parameter int              HDR_W     = 4,
  parameter logic [HDR_W-1:0] HEADER   = 4'b0101,
  parameter int              BIT_TICKS = 10,
  parameter int              PAR_MODE  = 0,
  parameter bit              MSB_FIRST = 1'b1,
  parameter logic            IDLE_LVL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic [DATA_W-1:0] message,
  output logic              data,
  output logic              ready,
  output logic              busy,
  output logic              done
);
  localparam int N  = HDR_W + DATA_W + ((PAR_MODE != 0) ? 1 : 0);
  localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int NW = $clog2(N);
  typedef enum logic {IDLE, SEND} state_t;
  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [NW-1:0]   bit_q, bit_d;
  logic [N-1:0]    sr_q, sr_d, frame;
  logic            data_q, data_d, done_q, done_d, par, last_tick;
  // frame is arranged so the first bit on the line sits at the MSB
  always_comb begin
    frame = '0;
    par = (PAR_MODE == 2) ? ~^message : ^message;
    for (int i = 0; i < HDR_W; i++) frame[N-1-i] = MSB_FIRST ? HEADER[HDR_W-1-i] : HEADER[i];
    for (int i = 0; i < DATA_W; i++) frame[N-1-HDR_W-i] = MSB_FIRST ? message[DATA_W-1-i] : message[i];
    if (PAR_MODE != 0) frame[0] = par;
  end
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    bit_d = bit_q;
    sr_d = sr_q;
    data_d = data_q;
    done_d = 1'b0;
    last_tick = tick_q == TW'(BIT_TICKS - 1);
    if (state_q == IDLE) begin
      if (send) begin
        state_d = SEND;
        tick_d = '0;
        bit_d = '0;
        sr_d = frame;
        data_d = frame[N-1];
      end
    end else begin
      tick_d = last_tick ? '0 : tick_q + 1'b1;
      if (last_tick && bit_q == NW'(N - 1)) begin
        state_d = IDLE;
        bit_d = '0;
        sr_d = '0;
        data_d = IDLE_LVL;
        done_d = 1'b1;
      end else if (last_tick) begin
        bit_d = bit_q + 1'b1;
        sr_d = {sr_q[N-2:0], 1'b0};
        data_d = sr_q[N-2];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      sr_q <= '0;
      data_q <= IDLE_LVL;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end
  assign data = data_q;
  assign busy = state_q == SEND;
  assign ready = state_q == IDLE;
  assign done = done_q;
endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: four parameterisations of frame_serializer checked cycle by cycle
// against expected line states queued when each frame is requested.
module tb_frame_serializer;
  logic clk = 1'b0, rst;
  logic send[4];
  logic [4:0] message[4];
  logic data[4], ready[4], busy[4], done[4];
  always #5 clk = ~clk;
  frame_serializer u0 (.clk(clk), .rst(rst), .send(send[0]), .message(message[0]),
    .data(data[0]), .ready(ready[0]), .busy(busy[0]), .done(done[0]));
  frame_serializer #(.PAR_MODE(1)) u1 (.clk(clk), .rst(rst), .send(send[1]), .message(message[1]),
    .data(data[1]), .ready(ready[1]), .busy(busy[1]), .done(done[1]));
  frame_serializer #(.PAR_MODE(2)) u2 (.clk(clk), .rst(rst), .send(send[2]), .message(message[2]),
    .data(data[2]), .ready(ready[2]), .busy(busy[2]), .done(done[2]));
  frame_serializer #(.MSB_FIRST(1'b0), .BIT_TICKS(1)) u3 (.clk(clk), .rst(rst), .send(send[3]),
    .message(message[3]), .data(data[3]), .ready(ready[3]), .busy(busy[3]), .done(done[3]));
  typedef struct {int u; logic [4:0] msg; logic [9:0] bits; int n; int bt;} vec_t;
  typedef struct {logic d; logic b; logic dn;} exp_t;
  exp_t q[$];
  vec_t vecs[8];
  int checks = 0, failures = 0;
  task automatic chk(string name, int u, int i, exp_t e);
    checks++;
    if ({data[u], busy[u], ready[u], done[u]} !== {e.d, e.b, ~e.b, e.dn}) begin
      failures++;
      $display("FAIL %s u%0d cyc%0d data/busy/ready/done got=%b%b%b%b exp=%b%b%b%b", name, u, i,
        data[u], busy[u], ready[u], done[u], e.d, e.b, ~e.b, e.dn);
    end
  endtask
  task automatic push_frame(logic [9:0] bits, int n, int bt);
    for (int i = 0; i < n; i++)
      for (int t = 0; t < bt; t++) q.push_back('{bits[n-1-i], 1'b1, 1'b0});
    q.push_back('{1'b0, 1'b0, 1'b1});
  endtask
  task automatic start(int u, logic [4:0] msg);
    @(negedge clk);
    send[u] = 1'b1;
    message[u] = msg;
    @(posedge clk);
    #1;
  endtask
  task automatic drain(string name, int u, logic [4:0] msg2, int drop_at, int pulse_at);
    int i = 0;
    while (q.size() > 0) begin
      chk(name, u, i, q.pop_front());
      if (i == 0) message[u] = msg2;
      if (i == drop_at) send[u] = 1'b0;
      if (i == pulse_at) begin
        send[u] = 1'b1;
        message[u] = 5'($urandom);
      end
      if (i == pulse_at + 1) send[u] = 1'b0;
      i++;
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    vecs[0] = '{0, 5'b10011, 10'b0010110011, 9, 10};
    vecs[1] = '{0, 5'b01100, 10'b0010101100, 9, 10};
    vecs[2] = '{1, 5'b10110, 10'b0101101101, 10, 10};
    vecs[3] = '{2, 5'b10110, 10'b0101101100, 10, 10};
    vecs[4] = '{1, 5'b00000, 10'b0101000000, 10, 10};
    vecs[5] = '{2, 5'b00000, 10'b0101000001, 10, 10};
    vecs[6] = '{3, 5'b00001, 10'b0101010000, 9, 1};
    vecs[7] = '{3, 5'b10110, 10'b0101001101, 9, 1};
    rst = 1'b1;
    for (int u = 0; u < 4; u++) begin
      send[u] = 1'b0;
      message[u] = 5'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) chk("reset", u, 0, '{1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[k]) begin
      q.delete();
      push_frame(vecs[k].bits, vecs[k].n, vecs[k].bt);
      q.push_back('{1'b0, 1'b0, 1'b0});
      start(vecs[k].u, vecs[k].msg);
      drain("vec", vecs[k].u, ~vecs[k].msg, 0, 3);
      repeat (2) @(posedge clk);
    end
    q.delete();
    push_frame(10'b0010111111, 9, 10);
    push_frame(10'b0010100000, 9, 10);
    q.push_back('{1'b0, 1'b0, 1'b0});
    start(0, 5'h1F);
    drain("hold", 0, 5'h00, 91, -10);
    start(0, 5'b10011);
    send[0] = 1'b0;
    repeat (37) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 0, 0, '{1'b0, 1'b0, 1'b0});
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("in_rst", 0, i, '{1'b0, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst", 0, i, '{1'b0, 1'b0, 1'b0});
    end
    q.delete();
    push_frame(vecs[0].bits, 9, 10);
    q.push_back('{1'b0, 1'b0, 1'b0});
    start(0, vecs[0].msg);
    drain("after_rst", 0, 5'b0, 0, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
